// File: rtl/uart_program_loader.sv
// UART program loader: receives a length-prefixed image over 8N1 serial and streams
// each payload byte into program memory through a simple byte-wide write port.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MEM_BYTES    = 1024,
    parameter int XLEN_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uart_rx,
    output logic                  write_enable,
    output logic [XLEN_WIDTH-1:0] write_address,
    output logic [7:0]            write_data,
    output logic                  loading,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(MEM_BYTES) + 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0]   MAX_LEN   = 32'(MEM_BYTES);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        LD_HDR,
        LD_DATA,
        LD_DONE
    } ld_state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and falling-edge detect
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       rx_s;
    logic       rx_prev;

    assign rx_s = sync_q[1];

    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, exactly like the hardware.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], uart_rx};
            rx_prev <= rx_s;
        end
    end

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    rx_state_t       rx_state;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_q;
    logic            stop_tick;
    logic            byte_valid;
    logic            frame_error;

    // The stop-bit sample cycle itself raises byte_valid so the loader can
    // register the memory write on the very next edge.
    assign stop_tick   = (rx_state == RX_STOP) && (clk_cnt == BIT_LAST);
    assign byte_valid  = stop_tick && rx_s;
    assign frame_error = stop_tick && !rx_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    if (rx_prev && !rx_s) begin
                        rx_state <= RX_START;
                        bit_cnt  <= '0;
                    end
                end

                RX_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt  <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                RX_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                RX_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt  <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame loader
    // ------------------------------------------------------------------
    ld_state_t      ld_state;
    logic [1:0]     hdr_cnt;
    logic [23:0]    len_q;
    logic [AW-1:0]  data_len;
    logic [AW-1:0]  addr_q;
    logic [31:0]    hdr_len;

    // Complete length as seen while the final header byte is being accepted.
    assign hdr_len = {shift_q, len_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_state      <= LD_HDR;
            hdr_cnt       <= '0;
            len_q         <= '0;
            data_len      <= '0;
            addr_q        <= '0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            loading       <= 1'b0;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
        end else begin
            // NOTE: strobes default low here and are raised only in the cycle that
            // needs them, which keeps them single-cycle without extra clear logic.
            write_enable <= 1'b0;
            load_done    <= 1'b0;

            if (frame_error) begin
                load_error <= 1'b1;
                loading    <= 1'b0;
                hdr_cnt    <= '0;
                ld_state   <= LD_HDR;
            end else begin
                case (ld_state)
                    LD_HDR: begin
                        if (byte_valid) begin
                            loading <= 1'b1;
                            hdr_cnt <= hdr_cnt + 1'b1;
                            case (hdr_cnt)
                                2'd0:    len_q[7:0]   <= shift_q;
                                2'd1:    len_q[15:8]  <= shift_q;
                                2'd2:    len_q[23:16] <= shift_q;
                                default: begin
                                    if (hdr_len == 32'd0) begin
                                        load_error <= 1'b0;
                                        ld_state   <= LD_DONE;
                                    end else if (hdr_len > MAX_LEN) begin
                                        load_error <= 1'b1;
                                        loading    <= 1'b0;
                                    end else begin
                                        load_error <= 1'b0;
                                        data_len   <= hdr_len[AW-1:0];
                                        addr_q     <= '0;
                                        ld_state   <= LD_DATA;
                                    end
                                end
                            endcase
                        end
                    end

                    LD_DATA: begin
                        if (byte_valid) begin
                            write_enable  <= 1'b1;
                            write_address <= XLEN_WIDTH'(addr_q);
                            write_data    <= shift_q;
                            addr_q        <= addr_q + 1'b1;
                            if (addr_q + AW'(1) == data_len) begin
                                ld_state <= LD_DONE;
                            end
                        end
                    end

                    LD_DONE: begin
                        load_done <= 1'b1;
                        loading   <= 1'b0;
                        hdr_cnt   <= '0;
                        ld_state  <= LD_HDR;
                    end

                    default: ld_state <= LD_HDR;
                endcase
            end
        end
    end

endmodule
